// File: rtl/vga_pkg.sv
// Image geometry and frame-marker constants shared by the UART loader,
// the image RAM and the rectangle drawer.
package vga_pkg;
  localparam int unsigned IMG_ADDR_W = 12;
  localparam int unsigned IMG_PIX    = 4096;
  localparam logic [7:0]  SYNC_BYTE  = 8'hA5;
endpackage

// File: rtl/byte_timeout.sv
// Inter-byte idle counter: flags expiry after CYCLES clocks without a kick.
module byte_timeout #(
  parameter int unsigned CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic kick,
  output logic expired
);
  localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !enable || kick) cnt <= '0;
    else                        cnt <= cnt + 1'b1;
  end

  // An arriving byte always beats expiry in the same cycle.
  assign expired = enable && !kick && (cnt == W'(CYCLES - 1));
endmodule

// File: rtl/uart_image_loader.sv
// Loads a 64x64 12-bit image from a UART byte stream: SYNC_BYTE, then
// two bytes per pixel (hi = R nibble, lo = G,B), row-major into image RAM.
module uart_image_loader
  import vga_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  SYNC_BYTE      = vga_pkg::SYNC_BYTE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  wr_en,
  output logic [IMG_ADDR_W-1:0] wr_addr,
  output logic [11:0]           wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;

  state_t                state, next_state;
  logic [IMG_ADDR_W-1:0] pix_cnt;
  logic [3:0]            r_lat;
  logic                  expired;
  logic                  sync_hit, hi_take, pix_wr, last_pix;

  assign sync_hit = (state == IDLE) && rx_valid && (rx_data == SYNC_BYTE);
  assign hi_take  = (state == WAIT_HI) && rx_valid;
  assign pix_wr   = (state == WAIT_LO) && rx_valid;
  assign last_pix = pix_wr && (pix_cnt == IMG_ADDR_W'(IMG_PIX - 1));

  byte_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .enable  (state != IDLE),
    .kick    (rx_valid),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (sync_hit) next_state = WAIT_HI;
      WAIT_HI: if (rx_valid) next_state = WAIT_LO;
               else if (expired) next_state = IDLE;
      WAIT_LO: if (last_pix) next_state = IDLE;
               else if (rx_valid) next_state = WAIT_HI;
               else if (expired) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // busy falls on the same edge that raises the final wr_en/done.
  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      pix_cnt <= '0;
      r_lat   <= '0;
    end else begin
      wr_en <= pix_wr;
      done  <= last_pix;
      if (hi_take) r_lat <= rx_data[3:0];
      if (pix_wr) begin
        wr_addr <= pix_cnt;
        wr_data <= {r_lat, rx_data};
        pix_cnt <= pix_cnt + 1'b1;
      end
      if (sync_hit) begin
        pix_cnt <= '0;
        err     <= 1'b0;
      end else if (expired) begin
        err   <= 1'b1;
        r_lat <= '0;
      end
    end
  end
endmodule

// File: tb/tb_uart_image_loader.sv
// Scoreboard bench: stimulus pushes expected writes, a negedge monitor pops them.
module tb_uart_image_loader;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [11:0] wr_data;
  logic        busy, done, err;

  typedef struct {
    logic [11:0] addr;
    logic [11:0] data;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;

  uart_image_loader #(.TIMEOUT_CYCLES(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Strobes b for one cycle; consecutive calls are 'space' cycles apart (space >= 2).
  task automatic send(input logic [7:0] b, input int space);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (space - 2) @(negedge clk);
  endtask

  task automatic expect_wr(input logic [11:0] a, input logic [11:0] d, input logic dn);
    exp_t e;
    e.addr = a; e.data = d; e.done = dn;
    exp_q.push_back(e);
  endtask

  task automatic send_pix(input logic [7:0] hi, input logic [7:0] lo, input logic [11:0] a,
                          input int space);
    send(hi, space);
    expect_wr(a, {hi[3:0], lo}, (a == 12'hFFF));
    send(lo, space);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every wr_en must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (wr_en) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: addr=%h data=%h", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          if (wr_addr !== e.addr || wr_data !== e.data || done !== e.done) begin
            errors++;
            $display("FAIL write: got addr=%h data=%h done=%b expected addr=%h data=%h done=%b",
                     wr_addr, wr_data, done, e.addr, e.data, e.done);
          end
        end
      end else if (done) begin
        checks++;
        errors++;
        $display("FAIL done_without_write: done=1 wr_en=0");
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    int base;
    rst = 1'b1; rx_data = '0; rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {wr_en, wr_addr, wr_data, busy, done, err}, '0);
    rst = 1'b0;

    // Junk in IDLE ignored; A5 after sync is pixel data.
    send(8'h3C, 2); send(8'h77, 2);
    chk("idle_not_busy", busy, 1'b0);
    send(8'hA5, 2);
    send_pix(8'h0F, 8'hA5, 12'h000, 2);
    repeat (3) @(negedge clk);
    chk("resync_q_empty", exp_q.size(), 0);
    chk("resync_busy", busy, 1'b1);

    // Timeout: one full pixel, then a partial one abandoned.
    do_reset();
    send(8'hA5, 2);
    send_pix(8'h01, 8'h23, 12'h000, 2);
    send(8'h04, 2);
    repeat (15) @(negedge clk);
    chk("timeout_not_early", err, 1'b0);
    chk("timeout_busy_early", busy, 1'b1);
    repeat (2) @(negedge clk);
    chk("timeout_err", err, 1'b1);
    chk("timeout_busy", busy, 1'b0);
    chk("timeout_q_empty", exp_q.size(), 0);
    chk("timeout_no_done", done_cnt, 0);
    send(8'hA5, 2);
    chk("sync_clears_err", err, 1'b0);
    chk("sync_sets_busy", busy, 1'b1);

    // Bytes 15 cycles apart never time out.
    do_reset();
    send(8'hA5, 15);
    send_pix(8'h0A, 8'hBC, 12'h000, 15);
    send_pix(8'h11, 8'h22, 12'h001, 15);
    send_pix(8'hF3, 8'h45, 12'h002, 15);
    chk("slow_err", err, 1'b0);
    chk("slow_busy", busy, 1'b1);
    chk("slow_q_empty", exp_q.size(), 0);

    // Reset mid-frame after 10 pixels.
    do_reset();
    send(8'hA5, 2);
    for (int i = 0; i < 10; i++) send_pix(8'h07, 8'(8'h10 + i), 12'(i), 2);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_outputs", {wr_en, wr_addr, wr_data, busy, done, err}, '0);
    rst = 1'b0;
    send(8'hA5, 2);
    send_pix(8'h0C, 8'hDE, 12'h000, 2);
    repeat (3) @(negedge clk);
    chk("restart_q_empty", exp_q.size(), 0);

    // Full frame then two stray bytes.
    do_reset();
    base = done_cnt;
    send(8'hA5, 2);
    for (int n = 0; n < 4096; n++) begin
      logic [11:0] nv;
      nv = 12'(n);
      send_pix({4'h0, nv[11:8]}, nv[7:0], nv, 2);
    end
    @(negedge clk);
    chk("frame_busy_low", busy, 1'b0);
    send(8'h00, 2); send(8'h01, 2);
    repeat (20) @(negedge clk);
    chk("frame_done_once", done_cnt - base, 1);
    chk("frame_q_empty", exp_q.size(), 0);
    chk("frame_err", err, 1'b0);
    chk("frame_idle", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
